// File: rtl/disp_scan_if.sv
// Bus between the CPU-side logic and the display scan controller: syscall
// capture inputs, display sources, and the scanned seven-segment outputs.
interface disp_scan_if;
  logic        syscall_valid;
  logic [31:0] syscall_code;
  logic [31:0] syscall_arg;
  logic [31:0] pc;
  logic [31:0] cycle_cnt;
  logic [1:0]  sel;
  logic        halt;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        state_dbg;

  // syscall_valid is a one-cycle pulse with no ready: the controller accepts
  // every pulse while running and drops all of them once halted.
  modport master (
    output syscall_valid, syscall_code, syscall_arg, pc, cycle_cnt, sel,
    input  halt, an, seg, state_dbg
  );
  modport slave (
    input  syscall_valid, syscall_code, syscall_arg, pc, cycle_cnt, sel,
    output halt, an, seg, state_dbg
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Syscall print/exit capture plus a time-multiplexed 8-digit hex display
// that snapshots the selected source once per scan to avoid tearing.
module disp_scan_ctrl #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic     clk,
  input  logic     rst,
  disp_scan_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           state;
  logic [31:0]      print_reg;
  logic [31:0]      print_cnt;
  logic [31:0]      snap;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [31:0]      src_mux;
  logic             slot_end;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    src_mux = print_reg;
    case (bus.sel)
      2'b00:   src_mux = print_reg;
      2'b01:   src_mux = bus.pc;
      2'b10:   src_mux = bus.cycle_cnt;
      default: src_mux = print_cnt;
    endcase
  end

  assign slot_end      = (div_cnt == DIV_LAST);
  assign bus.state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      bus.halt  <= 1'b0;
      print_reg <= '0;
      print_cnt <= '0;
      snap      <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
      bus.an    <= 8'hFF;
      bus.seg   <= 8'hFF;
    end else begin
      case (state)
        RUN: begin
          if (bus.syscall_valid) begin
            if (bus.syscall_code == 32'd10) begin
              state    <= HALT;
              bus.halt <= 1'b1;
            end else begin
              print_reg <= bus.syscall_arg;
              print_cnt <= print_cnt + 32'd1;
            end
          end
        end
        default: begin
          state    <= HALT;
          bus.halt <= 1'b1;
        end
      endcase

      // The snapshot is taken from pre-edge sources, so a print landing on the
      // wrap edge only reaches the display one scan later.
      if (slot_end) begin
        div_cnt <= '0;
        if (digit_idx == IDX_LAST) begin
          digit_idx <= '0;
          snap      <= src_mux;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      bus.an       <= ~(8'd1 << digit_idx);
      bus.seg[6:0] <= hex7(snap[4*digit_idx +: 4]);
      bus.seg[7]   <= ~(bus.halt && (digit_idx == '0));
    end
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a cycle model feeds an expected
// queue checked every cycle, plus directed scans of whole displayed values.
module tb_disp_scan_ctrl;
  localparam int CLK_DIV = 4;

  logic clk;
  logic rst;
  disp_scan_if bus ();

  disp_scan_ctrl #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // reference model, advanced on each clock edge
  logic [31:0] m_print, m_cnt, m_snap, m_mux;
  int          m_div, m_idx;
  logic        m_halt;
  logic [7:0]  e_an, e_seg;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_print = '0; m_cnt = '0; m_snap = '0;
      m_div = 0; m_idx = 0; m_halt = 1'b0;
      exp_q.delete();
    end else begin
      e_an  = ~(8'd1 << m_idx);
      e_seg = {~(m_halt && m_idx == 0), hex7(m_snap[4*m_idx +: 4])};
      case (bus.sel)
        2'b00:   m_mux = m_print;
        2'b01:   m_mux = bus.pc;
        2'b10:   m_mux = bus.cycle_cnt;
        default: m_mux = m_cnt;
      endcase
      if (m_div == CLK_DIV - 1) begin
        m_div = 0;
        if (m_idx == 7) begin
          m_idx  = 0;
          m_snap = m_mux;
        end else m_idx++;
      end else m_div++;
      if (!m_halt && bus.syscall_valid) begin
        if (bus.syscall_code == 32'd10) m_halt = 1'b1;
        else begin
          m_print = bus.syscall_arg;
          m_cnt   = m_cnt + 32'd1;
        end
      end
      exp_q.push_back({m_halt, e_an, e_seg});
    end
  end

  // scoreboard: pop one expectation per cycle, on the falling edge
  logic [16:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_halt", 32'(bus.halt), 32'd0);
      check("rst_an",   32'(bus.an),   32'hFF);
      check("rst_seg",  32'(bus.seg),  32'hFF);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cyc_halt", 32'(bus.halt), 32'(e[16]));
      check("cyc_an",   32'(bus.an),   32'(e[15:8]));
      check("cyc_seg",  32'(bus.seg),  32'(e[7:0]));
    end
  end

  // driver tasks; callers are positioned on a falling edge
  task automatic syscall(input logic [31:0] code, input logic [31:0] arg);
    #1;
    bus.syscall_valid = 1'b1;
    bus.syscall_code  = code;
    bus.syscall_arg   = arg;
    @(negedge clk);
    #1;
    bus.syscall_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] target, input string tag);
    logic [7:0] prev;
    int guard = 0;
    prev = bus.an;
    @(negedge clk);
    while (!(bus.an == target && prev != target) && guard < 200) begin
      prev = bus.an;
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(guard < 200), 32'd1);
  endtask

  task automatic expect_scan(input logic [31:0] val, input string tag);
    wait_an(8'hFE, {tag, "_sync"});
    for (int d = 0; d < 8; d++) begin
      check({tag, "_digit"}, 32'(bus.seg[6:0]), 32'(hex7(val[4*d +: 4])));
      if (d < 7) repeat (CLK_DIV) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b0;
    bus.syscall_valid = 1'b0;
    bus.syscall_code  = '0;
    bus.syscall_arg   = '0;
    bus.pc            = 32'h0000_0400;
    bus.cycle_cnt     = 32'h0000_0000;
    bus.sel           = 2'b00;

    // 1: reset and scan stepping
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("first_an",  32'(bus.an),  32'hFE);
    check("first_seg", 32'(bus.seg), 32'hC0);
    repeat (CLK_DIV) @(negedge clk);
    check("step_an", 32'(bus.an), 32'hFD);
    wait_an(8'h7F, "reach_7f");
    repeat (CLK_DIV) @(negedge clk);
    check("wrap_an", 32'(bus.an), 32'hFE);

    // 2: print
    wait_an(8'hF7, "align_print");
    syscall(32'd1, 32'h1234_ABCD);
    wait_an(8'hFE, "print_sync");
    check("print_d0_seg", 32'(bus.seg), 32'hA1);
    expect_scan(32'h1234_ABCD, "print");

    // 3: exit, then a print that must be ignored
    @(negedge clk);
    syscall(32'd10, 32'd0);
    check("halt_set", 32'(bus.halt), 32'd1);
    check("halt_state", 32'(bus.state_dbg), 32'd1);
    @(negedge clk);
    syscall(32'd1, 32'd5);
    wait_an(8'hFE, "halt_sync");
    check("halt_d0_seg", 32'(bus.seg), 32'h21);
    expect_scan(32'h1234_ABCD, "halted");
    check("halt_hold", 32'(bus.halt), 32'd1);

    // 4: source sharing
    #1 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    wait_an(8'hF7, "align_pc");
    #1;
    bus.sel = 2'b01;
    bus.pc  = 32'h0000_3000;
    expect_scan(32'h0000_3000, "pc");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      syscall(32'd1, $urandom);
    end
    wait_an(8'hF7, "align_cnt");
    #1 bus.sel = 2'b11;
    expect_scan(32'd3, "print_cnt");
    r = $urandom;
    wait_an(8'hF7, "align_cyc");
    #1;
    bus.sel       = 2'b10;
    bus.cycle_cnt = r;
    expect_scan(r, "cycle_cnt");

    // random prints on the print register
    wait_an(8'hF7, "align_rand");
    #1 bus.sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      wait_an(8'hF7, "align_rand_i");
      syscall(32'($urandom_range(0, 9)), r);
      expect_scan(r, "rand_print");
    end

    // 5: print on the wrap edge shows one scan late
    wait_an(8'h7F, "align_wrap");
    @(negedge clk);
    @(negedge clk);
    syscall(32'd7, 32'hCAFE_F00D);
    expect_scan(r, "wrap_old");
    expect_scan(32'hCAFE_F00D, "wrap_new");

    // exit and reset together: reset wins
    @(negedge clk);
    #1;
    bus.syscall_valid = 1'b1;
    bus.syscall_code  = 32'd10;
    rst               = 1'b0;
    @(negedge clk);
    #1;
    bus.syscall_valid = 1'b0;
    check("rst_win_halt", 32'(bus.halt), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_win_hold", 32'(bus.halt), 32'd0);
    check("rst_win_state", 32'(bus.state_dbg), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
